// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state encoding, default operand width and bus-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    // Half operand width; every data/key bus is twice this.
    localparam int RSA_WIDTH = 32;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Full data/key bus width for a given half width.
    function automatic int bus_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: holds the RSA key, range-checks a message, loads/runs the modexp core, returns the result.
// Latency: accept -> 1 LOAD cycle -> k+1 RUN cycles -> res_valid; range errors present res_valid the cycle after accept.
// Backpressure: msg_ready only in IDLE; result held in OUT until res_ready. Optional watchdog via RSA_EXP_TIMEOUT_EN.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH       = RSA_WIDTH,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_load,
    input  logic [2*WIDTH-1:0]   key_modulo,
    input  logic [2*WIDTH-1:0]   key_exponent,
    output logic                 key_busy,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [2*WIDTH-1:0]   msg_data,
    output logic [2*WIDTH-1:0]   exp_base,
    output logic [2*WIDTH-1:0]   exp_modulo,
    output logic [2*WIDTH-1:0]   exp_exponent,
    output logic                 exp_done,
    input  logic                 exp_finish,
    input  logic [2*WIDTH-1:0]   exp_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_err,
    output logic [CNT_W-1:0]     op_count
);

    localparam int DW = bus_w(WIDTH);

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   key_mod_reg;
    logic [DW-1:0]   key_exp_reg;
    logic [DW-1:0]   base_reg;
    logic            accept;
    logic            range_err;
    logic            tmo_hit;

    // A modulus below 2 has no valid residues; a message must be strictly below n.
    assign range_err = (key_mod_reg < DW'(2)) || (msg_data >= key_mod_reg);

    // The core reads the key straight from the holding registers.
    assign exp_modulo   = key_mod_reg;
    assign exp_exponent = key_exp_reg;
    assign exp_base     = base_reg;

`ifdef RSA_EXP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts RUN cycles; cleared in every other state so each operation starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_RUN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; a key_load in IDLE steals the cycle so the message sees the new key.
    always_comb begin
        state_nx  = state;
        msg_ready = 1'b0;
        key_busy  = 1'b1;
        exp_done  = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                key_busy  = 1'b0;
                msg_ready = !key_load;
                accept    = msg_valid && !key_load;
                if (accept) begin
                    state_nx = range_err ? ST_OUT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                exp_done = 1'b1;
                if (exp_finish || tmo_hit) begin
                    state_nx = ST_OUT;
                end
            end
            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Key capture is only honoured in IDLE so an operation never sees its key change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_mod_reg <= '0;
            key_exp_reg <= '0;
        end else if (state == ST_IDLE && key_load) begin
            key_mod_reg <= key_modulo;
            key_exp_reg <= key_exponent;
        end
    end

    // Base register changes only on an accepted message, keeping it stable through LOAD and RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg <= '0;
        end else if (accept) begin
            base_reg <= msg_data;
        end
    end

    // Result/status capture; untouched while OUT waits for res_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data <= '0;
            res_err  <= 1'b0;
            op_count <= '0;
        end else if (accept && range_err) begin
            res_data <= '0;
            res_err  <= 1'b1;
        end else if (state == ST_RUN && exp_finish) begin
            res_data <= exp_result;
            res_err  <= 1'b0;
            op_count <= op_count + CNT_W'(1);
        end else if (state == ST_RUN && tmo_hit) begin
            res_data <= '0;
            res_err  <= 1'b1;
        end
    end

endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
- Upstream sequencer for the modular-exponentiation core.
- Holds the RSA key (modulus n, exponent e or d) and accepts message blocks over a valid/ready stream.
- Range-checks each block, loads the core, drives the core's active-high `done` enable, and waits for its `finish`.
- Returns the result (ciphertext or plaintext) over an output valid/ready stream. One operation is in flight at a time.

Parameters:
- WIDTH, 32: half operand width; every data/key bus is 2*WIDTH bits, matching the core.
- CNT_W, 16: width of the completed-operation counter.
- TIMEOUT_CYC, 4*WIDTH+8: watchdog limit in cycles. Used only with RSA_EXP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_load  in  1  one-cycle strobe; capture key_modulo/key_exponent
- key_modulo  in  2*WIDTH  modulus n
- key_exponent  in  2*WIDTH  exponent e or d
- key_busy  out  1  high when not IDLE; key_load is ignored while high
- msg_valid  in  1  input block valid
- msg_ready  out  1  high only in IDLE
- msg_data  in  2*WIDTH  message block m
- exp_base  out  2*WIDTH  to core base
- exp_modulo  out  2*WIDTH  to core modulo
- exp_exponent  out  2*WIDTH  to core exponent
- exp_done  out  1  to core `done`; low = core reinitialises, high = core runs
- exp_finish  in  1  from core `finish`
- exp_result  in  2*WIDTH  from core result
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_data  out  2*WIDTH  result; 0 on error
- res_err  out  1  qualifies res_data: range or timeout error
- op_count  out  CNT_W  successful operations, wraps at 2^CNT_W

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; key registers=0; exp_done=0; res_valid=0; res_data=0; res_err=0; op_count=0.
  - Holding exp_done low also holds the core in its init state.
- States: IDLE, LOAD, RUN, OUT.
- IDLE:
  - msg_ready=1, exp_done=0.
  - key_load captures the key into registers. key_load is only honoured in IDLE.
  - If key_load and msg_valid are high in the same cycle, the key is captured and msg_ready is forced low that cycle, so the message waits for the new key.
  - On msg_valid&&msg_ready, m is registered into exp_base and checked:
    - key_modulo_reg<2 or m>=modulus -> OUT with res_err=1, res_data=0. The core is never run.
    - otherwise -> LOAD.
- LOAD:
  - Exactly one cycle with exp_done=0 and exp_base/exp_modulo/exp_exponent stable, so the core samples them on this edge.
  - Then -> RUN.
- RUN:
  - exp_done=1.
  - On exp_finish=1: register exp_result into res_data, res_err=0, op_count+1 -> OUT.
- OUT:
  - res_valid=1, exp_done=0. res_data/res_err are held stable until res_ready.
  - On res_valid&&res_ready -> IDLE, res_valid deasserts next cycle.
- Latency:
  - Handshake at cycle 0; LOAD at cycle 1; RUN from cycle 2.
  - With k = bit-length of the exponent, the core asserts finish after k+1 RUN cycles, and res_valid rises one cycle after finish is seen.
  - Exponent 0: finish after 1 RUN cycle, result 1.
- exp_modulo/exp_exponent are driven continuously from the key registers.
- exp_base changes only on an accepted message.
- reset_n assertion mid-RUN aborts the operation; op_count is cleared and no result is emitted.
- A stale exp_finish in IDLE or OUT is ignored.

Optional Feature:
- Macro: RSA_EXP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN.
  - On reaching TIMEOUT_CYC without exp_finish -> OUT with res_err=1, res_data=0, op_count unchanged.
  - exp_done drops on entry to OUT, which reinitialises the core.
- Undefined: no counter; RUN waits indefinitely for exp_finish.

Decomposition:
- Package rsa_pkg holds:
  - state encoding constants ST_IDLE/ST_LOAD/ST_RUN/ST_OUT;
  - the default WIDTH;
  - the data-bus width helper (2*WIDTH).
- No sub-module. Top-level integration instantiates rsa_exp_ctrl alongside the core, fed from a shared key source.

Test Plan:
- Encrypt: key n=3233, e=17; send m=65 -> res_data=2790, res_err=0, op_count=1; res_valid rises k+1+1 cycles after RUN entry (k=5).
- Decrypt: key n=3233, d=2753; send m=2790 -> res_data=65, res_err=0.
- Range error: n=3233, m=4000 -> res_err=1, res_data=0, exp_done never high, op_count unchanged. Repeat with n=1, m=0 -> same.
- Backpressure: res_ready held low 10 cycles after res_valid -> res_data stable, msg_ready=0, key_load ignored. Release -> IDLE, next message accepted.
- Exponent 0 with simultaneous events: key e=0 and msg_valid asserted in the same cycle as key_load -> message accepted one cycle later, result 1. Separately, assert reset_n low mid-RUN -> all outputs at reset values immediately, no res_valid.
- Timeout (RSA_EXP_TIMEOUT_EN defined): tie exp_finish=0 -> after TIMEOUT_CYC RUN cycles, res_err=1, res_data=0, exp_done=0.
